// File: rtl/ascon_sbox_layer_seq.sv
// Column sequencer for the masked ASCON S-box layer: streams 64 share-packed columns
// through one external S-box, one per randomness handshake, writing results back in place.
module ascon_sbox_layer_seq #(
  parameter int D      = 2,
  parameter int NS     = D + 1,
  parameter int N_COLS = 64,
  parameter int RW     = NS * D / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     masked_en,
  input  logic [5*N_COLS*NS-1:0]   state_in,
  output logic [5*N_COLS*NS-1:0]   state_out,
  output logic                     busy,
  output logic                     done,
  input  logic [RW-1:0]            rnd_data,
  input  logic                     rnd_valid,
  output logic                     rnd_ready,
  output logic [5*NS-1:0]          sbox_x_in,
  output logic [RW-1:0]            sbox_fresh_r,
  output logic                     sbox_sel_masked,
  input  logic [5*NS-1:0]          sbox_x_out
);

  localparam int              SW       = 5 * N_COLS * NS;
  localparam int              CW       = $clog2(N_COLS);
  localparam logic [CW:0]     COL_END  = N_COLS[CW:0];
  localparam logic [CW:0]     LAST_COL = COL_END - 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [CW:0]   col_cnt;
  logic          pend_vld_p1;
  logic [CW-1:0] pend_col_p1;
  logic [SW-1:0] st_q;
  logic          accept;
  logic          issue;
  logic          last_issue;

  assign accept     = (fsm_q == IDLE) && start;
  assign issue      = rnd_valid && rnd_ready;
  assign last_issue = issue && (col_cnt == LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start) fsm_d = RUN;
      RUN:     if (last_issue) fsm_d = DRAIN;
      DRAIN:   fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    rnd_ready    = (fsm_q == RUN) && (col_cnt < COL_END);
    sbox_fresh_r = rnd_data;
    sbox_x_in    = '0;
    if (fsm_q == RUN) begin
      for (int l = 0; l < 5; l++) begin
        for (int s = 0; s < NS; s++) begin
          sbox_x_in[l*NS+s] = st_q[(l*N_COLS + int'(col_cnt[CW-1:0]))*NS + s];
        end
      end
    end
  end

  // issue edge -> p1: remember which column the S-box is now holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt         <= '0;
      pend_vld_p1     <= 1'b0;
      pend_col_p1     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      sbox_sel_masked <= 1'b0;
    end else begin
      done        <= (fsm_q == DRAIN);
      pend_vld_p1 <= issue;
      if (issue) begin
        pend_col_p1 <= col_cnt[CW-1:0];
        col_cnt     <= col_cnt + 1'b1;
      end
      if (accept) begin
        col_cnt         <= '0;
        busy            <= 1'b1;
        sbox_sel_masked <= masked_en;
      end else if (fsm_q == DRAIN) begin
        busy <= 1'b0;
      end
    end
  end

  // p1 capture: write the S-box result back over the column it came from
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else if (accept) begin
      st_q <= state_in;
    end else if (pend_vld_p1) begin
      for (int l = 0; l < 5; l++) begin
        for (int s = 0; s < NS; s++) begin
          st_q[(l*N_COLS + int'(pend_col_p1))*NS + s] <= sbox_x_out[l*NS+s];
        end
      end
    end
  end

  assign state_out = st_q;

endmodule

// File: tb/tb_ascon_sbox_layer_seq.sv
// Bench for ascon_sbox_layer_seq: behavioural S-box/PRNG stand-ins and a chi model on
// recombined shares, with directed corner layers followed by randomized layers.
module tb_ascon_sbox_layer_seq;
  localparam int D  = 2;
  localparam int NS = D + 1;
  localparam int RW = NS * D / 2;
  localparam int NC = 64;
  localparam int SW = 5 * NC * NS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          masked_en = 1'b0;
  logic          rnd_valid = 1'b0;
  logic [SW-1:0] state_in = '0;
  logic [SW-1:0] state_out;
  logic          busy, done, rnd_ready, sbox_sel_masked;
  logic [RW-1:0] rnd_data = '0;
  logic [RW-1:0] sbox_fresh_r;
  logic [5*NS-1:0] sbox_x_in;
  logic [5*NS-1:0] sbox_x_out = '0;

  int hs_cnt = 0, rdy_bad = 0, xin_bad = 0, fr_bad = 0;
  int n_chk = 0, n_err = 0;

  ascon_sbox_layer_seq #(.D(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .masked_en(masked_en),
    .state_in(state_in), .state_out(state_out), .busy(busy), .done(done),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sbox_x_in(sbox_x_in), .sbox_fresh_r(sbox_fresh_r),
    .sbox_sel_masked(sbox_sel_masked), .sbox_x_out(sbox_x_out)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] chi5(input logic [4:0] x);
    logic [4:0] y;
    for (int i = 0; i < 5; i++) y[i] = x[i] ^ (~x[(i+1)%5] & x[(i+2)%5]);
    return y;
  endfunction

  function automatic logic [SW-1:0] mask_state(input logic [319:0] p);
    logic [SW-1:0] m;
    logic acc, r;
    m = '0;
    for (int i = 0; i < 320; i++) begin
      acc = p[i];
      for (int s = 1; s < NS; s++) begin
        r = 1'($urandom);
        m[i*NS+s] = r;
        acc ^= r;
      end
      m[i*NS] = acc;
    end
    return m;
  endfunction

  function automatic logic [319:0] unmask(input logic [SW-1:0] m);
    logic [319:0] p;
    for (int i = 0; i < 320; i++) p[i] = ^m[i*NS +: NS];
    return p;
  endfunction

  function automatic logic [4:0] col_of(input logic [319:0] p, input int b);
    logic [4:0] x;
    for (int l = 0; l < 5; l++) x[l] = p[l*NC+b];
    return x;
  endfunction

  function automatic logic [319:0] chi_layer(input logic [319:0] p);
    logic [319:0] q;
    logic [4:0] y;
    for (int b = 0; b < NC; b++) begin
      y = chi5(col_of(p, b));
      for (int l = 0; l < 5; l++) q[l*NC+b] = y[l];
    end
    return q;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] p;
    for (int i = 0; i < 10; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // S-box stand-in: registers a fresh re-sharing of chi on issue, garbage otherwise
  always @(posedge clk) begin
    logic [4:0] x, y;
    logic [5*NS-1:0] o;
    logic acc, r;
    if (rnd_valid && rnd_ready) begin
      x = '0;
      for (int l = 0; l < 5; l++)
        for (int s = 0; s < NS; s++) x[l] ^= sbox_x_in[l*NS+s];
      y = chi5(x);
      for (int l = 0; l < 5; l++) begin
        acc = y[l];
        for (int s = 1; s < NS; s++) begin
          r = 1'($urandom);
          o[l*NS+s] = r;
          acc ^= r;
        end
        o[l*NS] = acc;
      end
      sbox_x_out <= o;
      hs_cnt <= hs_cnt + 1;
    end else begin
      sbox_x_out <= (5*NS)'($urandom);
    end
    if (rnd_ready && !busy) rdy_bad <= rdy_bad + 1;
    if (!busy && sbox_x_in != '0) xin_bad <= xin_bad + 1;
    if (sbox_fresh_r != rnd_data) fr_bad <= fr_bad + 1;
  end

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode 0: rnd_valid always 1; 1: toggles starting low; 2: random with ~1/8 low
  task automatic run_layer(input logic [319:0] plain, input bit me, input int mode,
                           input int restart_at, input int rst_at,
                           output int done_n, output int busy_n, output int hs,
                           output int exp_done);
    int iss, hs0;
    bit v;
    iss = 0; done_n = -1; busy_n = 0; exp_done = -1;
    state_in  = mask_state(plain);
    masked_en = me;
    start     = 1'b1;
    rnd_valid = 1'b0;
    hs0 = hs_cnt;
    @(negedge clk);
    start     = 1'b0;
    masked_en = ~me;
    for (int n = 1; n <= 400; n++) begin
      if (done) begin
        done_n = n;
        break;
      end
      if (busy) busy_n++;
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", rnd_ready, 0);
        check("rst_state", |state_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      if (n == 2) check("sel_masked", sbox_sel_masked, me);
      start = (n == restart_at);
      if (n == restart_at) state_in = mask_state(~plain);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (n % 2 == 0);
      else                v = ($urandom % 8) != 0;
      rnd_valid = v;
      rnd_data  = RW'($urandom);
      if (v && iss < NC) begin
        iss++;
        if (iss == NC) exp_done = n + 2;
      end
      @(negedge clk);
    end
    start     = 1'b0;
    rnd_valid = 1'b0;
    hs = hs_cnt - hs0;
  endtask

  initial begin
    logic [319:0] p, g;
    int dn, bn, hs, ed;

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", rnd_ready, 0);
    check("reset_sel", sbox_sel_masked, 0);
    check("reset_state", |state_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single x0 bit in column 7
    p = '0; p[7] = 1'b1; g = chi_layer(p);
    run_layer(p, 1'b1, 0, 0, 0, dn, bn, hs, ed);
    check("x0_done_lat", dn, 66);
    check("x0_state", unmask(state_out), g);
    check("x0_col7", col_of(unmask(state_out), 7), 5'b01001);
    check("x0_handshakes", hs, 64);
    state_in = mask_state(~p);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("hold_after_done", unmask(state_out), g);

    // all ones
    p = '1;
    run_layer(p, 1'b0, 0, 0, 0, dn, bn, hs, ed);
    check("ones_state", unmask(state_out), {320{1'b1}});
    check("ones_busy_cycles", bn, 65);
    check("ones_done_lat", dn, 66);

    // alternating randomness availability
    p = rand320(); g = chi_layer(p);
    run_layer(p, 1'b1, 1, 0, 0, dn, bn, hs, ed);
    check("toggle_done_lat", dn, 130);
    check("toggle_handshakes", hs, 64);
    check("toggle_state", unmask(state_out), g);

    // start re-pulsed mid-layer with a different state
    p = rand320(); g = chi_layer(p);
    run_layer(p, 1'b1, 0, 10, 0, dn, bn, hs, ed);
    check("restart_done_lat", dn, 66);
    check("restart_state", unmask(state_out), g);

    // abort at column 30, then a clean layer
    p = rand320();
    run_layer(p, 1'b1, 0, 0, 31, dn, bn, hs, ed);
    p = rand320(); g = chi_layer(p);
    run_layer(p, 1'b0, 2, 0, 0, dn, bn, hs, ed);
    check("post_rst_state", unmask(state_out), g);
    check("post_rst_done_lat", dn, ed);
    check("post_rst_handshakes", hs, 64);

    for (int k = 0; k < 1000; k++) begin
      p = rand320(); g = chi_layer(p);
      run_layer(p, k[0], (k % 8 == 0) ? 2 : 0, 0, 0, dn, bn, hs, ed);
      check("rnd_state", unmask(state_out), g);
      check("rnd_done_lat", dn, ed);
    end

    check("ready_outside_run", rdy_bad, 0);
    check("xin_outside_run", xin_bad, 0);
    check("fresh_passthrough", fr_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
